// File: rtl/mmu_pkg.sv
// Shared definitions for the TLB-based MMU: default page geometry, FSM encoding and
// virtual-address split helpers.
package mmu_pkg;

    localparam int unsigned DEF_PAGE_NUM_WIDTH = 20;
    localparam int unsigned DEF_ENTRIES        = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FAULT = 1'b1
    } mmu_state_e;

    // Page number right-aligned in a 32-bit word; callers truncate to their page width.
    function automatic logic [31:0] page_of(input logic [31:0] vaddr, input int unsigned pw);
        return vaddr >> (32 - pw);
    endfunction

    function automatic logic [31:0] offset_of(input logic [31:0] vaddr, input int unsigned pw);
        return vaddr & ((32'h1 << (32 - pw)) - 32'h1);
    endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative TLB storage: parallel page compare for lookups and updates,
// match encoding and round-robin allocation of new mappings.
module tlb_cam
    import mmu_pkg::*;
#(
    parameter int unsigned PAGE_NUM_WIDTH = DEF_PAGE_NUM_WIDTH,
    parameter int unsigned ENTRIES        = DEF_ENTRIES,
    localparam int unsigned IDX_W         = $clog2(ENTRIES)
) (
    input  logic                      i_clk,
    input  logic                      i_clr,
    input  logic [PAGE_NUM_WIDTH-1:0] i_lk_page,
    output logic                      o_hit,
    output logic [IDX_W-1:0]          o_hit_idx,
    output logic [PAGE_NUM_WIDTH-1:0] o_hit_ppage,
    input  logic                      i_upd,
    input  logic [PAGE_NUM_WIDTH-1:0] i_upd_vpage,
    input  logic [PAGE_NUM_WIDTH-1:0] i_upd_ppage,
    input  logic                      i_flush,
    output logic [IDX_W-1:0]          o_wr_idx
);

    logic [ENTRIES-1:0]        r_valid;
    logic [PAGE_NUM_WIDTH-1:0] r_vpage [ENTRIES];
    logic [PAGE_NUM_WIDTH-1:0] r_ppage [ENTRIES];
    logic [IDX_W-1:0]          r_rr_ptr;

    logic                      w_upd_match;
    logic [IDX_W-1:0]          w_upd_match_idx;

    // Updates never create duplicates, so at most one entry matches any page.
    always_comb begin
        o_hit           = 1'b0;
        o_hit_idx       = '0;
        o_hit_ppage     = '0;
        w_upd_match     = 1'b0;
        w_upd_match_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (r_valid[i] && (r_vpage[i] == i_lk_page)) begin
                o_hit       = 1'b1;
                o_hit_idx   = IDX_W'(i);
                o_hit_ppage = r_ppage[i];
            end
            if (r_valid[i] && (r_vpage[i] == i_upd_vpage)) begin
                w_upd_match     = 1'b1;
                w_upd_match_idx = IDX_W'(i);
            end
        end
    end

    // Flush takes effect before a same-cycle write, so that write always lands in entry 0.
    assign o_wr_idx = i_flush     ? '0 :
                      w_upd_match ? w_upd_match_idx : r_rr_ptr;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_valid  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (i_flush) begin
                r_valid  <= '0;
                r_rr_ptr <= '0;
            end
            if (i_upd) begin
                r_vpage[o_wr_idx] <= i_upd_vpage;
                r_ppage[o_wr_idx] <= i_upd_ppage;
                r_valid[o_wr_idx] <= 1'b1;
                if (i_flush) begin
                    r_rr_ptr <= IDX_W'(1);
                end else if (!w_upd_match) begin
                    r_rr_ptr <= r_rr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// User-mode address translation through an ENTRIES-deep TLB with one-cycle registered
// latency, kernel-mode bypass and a sticky miss fault held until acknowledged.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned PAGE_NUM_WIDTH = DEF_PAGE_NUM_WIDTH,
    parameter int unsigned ENTRIES        = DEF_ENTRIES,
    localparam int unsigned IDX_W         = $clog2(ENTRIES)
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      mmu_en,
    input  logic                      lookup_valid,
    input  logic [31:0]               vaddr_in,
    input  logic                      mmu_update,
    input  logic [PAGE_NUM_WIDTH-1:0] vpage_in,
    input  logic [PAGE_NUM_WIDTH-1:0] ppage_in,
    input  logic                      flush,
    input  logic                      fault_ack,
    output logic [31:0]               paddr_o,
    output logic                      paddr_valid_o,
    output logic                      mmu_error_o,
    output logic [31:0]               badvaddr_o,
    output logic [IDX_W-1:0]          hit_idx_o
);

    mmu_state_e                r_state;
    mmu_state_e                w_state_next;
    logic [31:0]               r_paddr;
    logic                      r_paddr_valid;
    logic [31:0]               r_badvaddr;
    logic [IDX_W-1:0]          r_hit_idx;

    logic [PAGE_NUM_WIDTH-1:0] w_lk_page;
    logic                      w_cam_hit;
    logic [IDX_W-1:0]          w_cam_idx;
    logic [PAGE_NUM_WIDTH-1:0] w_cam_ppage;
    logic [IDX_W-1:0]          w_wr_idx;
    logic                      w_fwd_hit;
    logic                      w_hit;
    logic [IDX_W-1:0]          w_hit_idx;
    logic [PAGE_NUM_WIDTH-1:0] w_ppage;
    logic                      w_service;
    logic [31:0]               w_xlat_paddr;

    assign w_lk_page = PAGE_NUM_WIDTH'(page_of(vaddr_in, PAGE_NUM_WIDTH));

    tlb_cam #(
        .PAGE_NUM_WIDTH(PAGE_NUM_WIDTH),
        .ENTRIES       (ENTRIES)
    ) u_cam (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_lk_page  (w_lk_page),
        .o_hit      (w_cam_hit),
        .o_hit_idx  (w_cam_idx),
        .o_hit_ppage(w_cam_ppage),
        .i_upd      (mmu_update),
        .i_upd_vpage(vpage_in),
        .i_upd_ppage(ppage_in),
        .i_flush    (flush),
        .o_wr_idx   (w_wr_idx)
    );

    // A mapping being written this cycle wins over whatever is stored.
    assign w_fwd_hit    = mmu_update && (vpage_in == w_lk_page);
    assign w_hit        = w_fwd_hit || w_cam_hit;
    assign w_hit_idx    = w_fwd_hit ? w_wr_idx : w_cam_idx;
    assign w_ppage      = w_fwd_hit ? ppage_in : w_cam_ppage;
    assign w_xlat_paddr = (32'(w_ppage) << (32 - PAGE_NUM_WIDTH))
                        | offset_of(vaddr_in, PAGE_NUM_WIDTH);
    assign w_service    = lookup_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_service && mmu_en && !w_hit) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_paddr       <= '0;
            r_paddr_valid <= 1'b0;
            r_badvaddr    <= '0;
            r_hit_idx     <= '0;
        end else begin
            r_paddr_valid <= 1'b0;
            if (w_service) begin
                if (!mmu_en) begin
                    r_paddr       <= vaddr_in;
                    r_paddr_valid <= 1'b1;
                end else if (w_hit) begin
                    r_paddr       <= w_xlat_paddr;
                    r_paddr_valid <= 1'b1;
                    r_hit_idx     <= w_hit_idx;
                end else begin
                    r_badvaddr <= vaddr_in;
                end
            end
        end
    end

    assign paddr_o       = r_paddr;
    assign paddr_valid_o = r_paddr_valid;
    assign mmu_error_o   = (r_state == ST_FAULT);
    assign badvaddr_o    = r_badvaddr;
    assign hit_idx_o     = r_hit_idx;

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Parametrised successor to the single-page MMU: an ENTRIES-deep, fully-associative TLB of virtual-to-physical page mappings.
- Sits between the CU/address generation and the memory bus.
- Translates user-mode addresses with one-cycle registered latency. Kernel mode passes addresses through untranslated.
- A miss raises a sticky fault and captures the bad address until the CU acknowledges it.

Parameters:
- PAGE_NUM_WIDTH, 20: page-number width; page offset is 32-PAGE_NUM_WIDTH bits (default gives 4KB pages).
- ENTRIES, 4: number of TLB entries; power of two, range 2..16.
- IDX_W, $clog2(ENTRIES): entry index width (derived, not overridable).

Ports:
- clk  in  1  clock
- clr  in  1  reset
- mmu_en  in  1  1 = user mode (translate), 0 = kernel mode (bypass)
- lookup_valid  in  1  vaddr_in carries a request this cycle
- vaddr_in  in  32  virtual address
- mmu_update  in  1  write a mapping (valid eret / CU TLB write)
- vpage_in  in  PAGE_NUM_WIDTH  virtual page number to write
- ppage_in  in  PAGE_NUM_WIDTH  physical page number to write
- flush  in  1  invalidate all entries
- fault_ack  in  1  CU has taken the fault
- paddr_o  out  32  translated physical address
- paddr_valid_o  out  1  paddr_o valid for the previous cycle's request
- mmu_error_o  out  1  sticky translation fault
- badvaddr_o  out  32  vaddr of the faulting request
- hit_idx_o  out  IDX_W  entry that hit (debug/perf)

Behaviour:
- Reset: clk posedge with clr=1, synchronous, active-high.
  - Clears all entry valid bits, replacement pointer (rr_ptr) and FSM (to IDLE).
  - Outputs after reset: paddr_o=0, paddr_valid_o=0, mmu_error_o=0, badvaddr_o=0, hit_idx_o=0.
  - clr overrides every other input, including mid-fault.
- Storage: per entry a valid bit, vpage[PAGE_NUM_WIDTH] and ppage[PAGE_NUM_WIDTH].
- Lookup: combinational compare of vaddr_in[31:32-PAGE_NUM_WIDTH] against all valid entries. All outputs are registered, so latency is exactly 1 cycle.
- Same-cycle update forwarding: when mmu_update=1 in the same cycle as a lookup, the incoming (vpage_in, ppage_in) pair takes part in the compare and takes priority over stored entries.
- Kernel mode: when mmu_en=0, paddr_o=vaddr_in, paddr_valid_o=1 and no fault is raised, whatever the TLB contents.
- User hit: paddr_o={ppage, vaddr_in offset bits}, paddr_valid_o=1, hit_idx_o=matching index. A forwarded hit reports the index being written.
- User miss: paddr_valid_o=0, badvaddr_o<=vaddr_in, mmu_error_o<=1, FSM moves to FAULT.
- FSM states:
  - IDLE: lookups serviced.
  - FAULT: lookups ignored (paddr_valid_o=0), mmu_error_o and badvaddr_o held.
  - FAULT -> IDLE on fault_ack. mmu_error_o drops the following cycle.
  - A lookup presented in the same cycle as fault_ack is ignored.
  - fault_ack in IDLE has no effect.
  - Updates and flush are accepted in both states.
- Update allocation:
  - If vpage_in matches a valid entry, that entry's ppage is overwritten and rr_ptr is unchanged. No duplicate mappings are ever created.
  - Otherwise the entry at rr_ptr is written and marked valid, and rr_ptr increments, wrapping ENTRIES-1 -> 0. No invalid-first preference.
- Flush: all valid bits cleared and rr_ptr reset to 0.
  - flush and mmu_update in the same cycle: flush applies first, then the write lands in entry 0 and rr_ptr becomes 1.
  - A lookup in the same cycle as flush sees the pre-flush contents plus forwarding.
- paddr_valid_o is a single-cycle pulse per serviced request. paddr_o holds its last value when paddr_valid_o=0.

Decomposition:
- Package mmu_pkg: PAGE_NUM_WIDTH default, FSM state encoding (ST_IDLE, ST_FAULT), and a function splitting vaddr into page/offset.
- One sub-module, tlb_cam: entry storage, parallel compare, one-hot to index encoder and rr_ptr allocation.
- The top level holds the forwarding mux, the FSM and the output registers.

Test Plan:
- Kernel bypass: clr, then mmu_en=0, vaddr 0x1234_5678 -> next cycle paddr_o=0x1234_5678, paddr_valid_o=1, mmu_error_o=0.
- Fill and hit: write (0x00400->0x00010), (0x00401->0x00011); user lookup 0x0040_1ABC -> paddr_o=0x0001_1ABC, hit_idx_o=1.
- Forwarding: mmu_update (0x7FFFF->0x00020) in the same cycle as lookup 0x7FFF_F004 -> paddr_o=0x0002_0004, no fault.
- Wrap/replace (ENTRIES=4): write 5 distinct vpages 0x100..0x104 -> 0x100 evicted; lookup 0x0010_0000 -> mmu_error_o=1, badvaddr_o=0x0010_0000; a following lookup is ignored; fault_ack -> error clears next cycle.
- Rewrite: write 0x200->0x30 then 0x200->0x31 -> rr_ptr advanced once; lookup hits with ppage 0x31.
- Flush and reset: flush+update (0x300->0x40) -> only entry 0 valid. Assert clr during FAULT -> all outputs 0 next cycle; a prior hit now misses.
